// File: rtl/demux4_reg.sv
// demux4_reg
// Registered 1-to-4 demultiplexer. One valid/ready input stream is steered
// by `selector` into one of four one-entry holding registers. Each register
// has its own valid/ready handshake toward its consumer.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   selector   destination of the current input beat (0..3 -> ch0..ch3)
//   in_valid   input beat present
//   in_data    input beat payload
//   in_ready   input beat accepted this cycle when in_valid && in_ready
//   out_valid  bit k: channel k holds a beat
//   out_ready  bit k: consumer k takes the beat this cycle
//   out00..11  payload held for ch0..ch3
module demux4_reg #(
  parameter int BUS_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           selector,
  input  logic                 in_valid,
  input  logic [BUS_WIDTH-1:0] in_data,
  output logic                 in_ready,
  output logic [3:0]           out_valid,
  input  logic [3:0]           out_ready,
  output logic [BUS_WIDTH-1:0] out00,
  output logic [BUS_WIDTH-1:0] out01,
  output logic [BUS_WIDTH-1:0] out10,
  output logic [BUS_WIDTH-1:0] out11
);

  logic [3:0]           full_q, full_d;
  logic [BUS_WIDTH-1:0] data_q [4];
  logic [BUS_WIDTH-1:0] data_d [4];
  logic                 accept;

  // A full channel can still take a beat in the same cycle it is drained,
  // which gives one beat per cycle into a single channel with no bubble.
  assign in_ready = !full_q[selector] || out_ready[selector];
  assign accept   = in_valid && in_ready;

  always_comb begin
    full_d = full_q & ~out_ready;
    for (int k = 0; k < 4; k++) begin
      data_d[k] = data_q[k];
    end
    // Load wins over drain on the same channel.
    if (accept) begin
      full_d[selector] = 1'b1;
      data_d[selector] = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= '0;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      full_q <= full_d;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign out_valid = full_q;
  assign out00     = data_q[0];
  assign out01     = data_q[1];
  assign out10     = data_q[2];
  assign out11     = data_q[3];

endmodule

// File: tb/tb_demux4_reg.sv
module tb_demux4_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  selector;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out00, out01, out10, out11;

  int checks = 0;
  int errors = 0;

  demux4_reg #(.BUS_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .selector  (selector),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out00     (out00),
    .out01     (out01),
    .out10     (out10),
    .out11     (out11)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 32'hDEADBEEF; selector = 2'd2;
    out_ready = 4'b0000;
    step();
    step();
    checks++;
    if (out_valid !== 4'b0000) begin
      errors++; $display("FAIL reset_valid got %b want 0000", out_valid);
    end
    checks++;
    if ({out00, out01, out10, out11} !== 128'd0) begin
      errors++; $display("FAIL reset_data got %h %h %h %h want all 0", out00, out01, out10, out11);
    end
    rst = 1'b0; in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 4'b0000) begin
      errors++; $display("FAIL reset_idle got %b want 0000", out_valid);
    end
  endtask

  task automatic test_single_route();
    selector = 2'd2; in_data = 32'hA5A5_0002; in_valid = 1'b1; out_ready = 4'b0000;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 4'b0100 || out10 !== 32'hA5A5_0002) begin
      errors++; $display("FAIL route_load got %b %h want 0100 a5a50002", out_valid, out10);
    end
    checks++;
    if (out00 !== 32'd0 || out01 !== 32'd0 || out11 !== 32'd0) begin
      errors++; $display("FAIL route_others got %h %h %h want 0", out00, out01, out11);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (out_valid !== 4'b0100 || out10 !== 32'hA5A5_0002) begin
        errors++; $display("FAIL route_hold%0d got %b %h want 0100 a5a50002", i, out_valid, out10);
      end
    end
    out_ready = 4'b0100;
    step();
    out_ready = 4'b0000;
    checks++;
    if (out_valid !== 4'b0000) begin
      errors++; $display("FAIL route_drain got %b want 0000", out_valid);
    end
  endtask

  task automatic test_back_pressure();
    selector = 2'd1; in_data = 32'h55; in_valid = 1'b1; out_ready = 4'b0000;
    step();
    in_data = 32'h11;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_ready got %b want 0", in_ready);
    end
    step();
    checks++;
    if (out_valid !== 4'b0010 || out01 !== 32'h55) begin
      errors++; $display("FAIL bp_hold got %b %h want 0010 00000055", out_valid, out01);
    end
    selector = 2'd3;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_resel_ready got %b want 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 4'b1010 || out11 !== 32'h11 || out01 !== 32'h55) begin
      errors++; $display("FAIL bp_land got %b %h %h want 1010 00000011 00000055", out_valid, out11, out01);
    end
    out_ready = 4'b1010;
    step();
    out_ready = 4'b0000;
    checks++;
    if (out_valid !== 4'b0000) begin
      errors++; $display("FAIL bp_drain got %b want 0000", out_valid);
    end
  endtask

  task automatic test_streaming();
    selector = 2'd0; out_ready = 4'b0001; in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = i;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL stream_ready%0d got %b want 1", i, in_ready);
      end
      step();
      checks++;
      if (out_valid[0] !== 1'b1 || out00 !== i) begin
        errors++; $display("FAIL stream_data%0d got %b %h want 1 %h", i, out_valid[0], out00, i);
      end
    end
    in_valid = 1'b0;
    step();
    out_ready = 4'b0000;
    checks++;
    if (out_valid !== 4'b0000) begin
      errors++; $display("FAIL stream_drain got %b want 0000", out_valid);
    end
  endtask

  task automatic test_round_robin();
    out_ready = 4'b0000; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      selector = k[1:0]; in_data = 32'd10 + k;
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 4'b1111) begin
      errors++; $display("FAIL rr_valid got %b want 1111", out_valid);
    end
    checks++;
    if (out00 !== 32'd10 || out01 !== 32'd11 || out10 !== 32'd12 || out11 !== 32'd13) begin
      errors++; $display("FAIL rr_data got %0d %0d %0d %0d want 10 11 12 13", out00, out01, out10, out11);
    end
    out_ready = 4'b1010;
    step();
    checks++;
    if (out_valid !== 4'b0101 || out00 !== 32'd10 || out10 !== 32'd12) begin
      errors++; $display("FAIL rr_partial got %b %0d %0d want 0101 10 12", out_valid, out00, out10);
    end
    out_ready = 4'b1111;
    step();
    out_ready = 4'b0000;
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; selector = 2'd0; in_data = 32'hC0;
    step();
    selector = 2'd3; in_data = 32'hC3;
    step();
    checks++;
    if (out_valid !== 4'b1001) begin
      errors++; $display("FAIL rmid_setup got %b want 1001", out_valid);
    end
    selector = 2'd1; in_data = 32'h77; rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL rmid_ready got %b want 1", in_ready);
    end
    step();
    rst = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 4'b0000 || out01 !== 32'd0 || out00 !== 32'd0 || out11 !== 32'd0) begin
      errors++; $display("FAIL rmid_clear got %b %h %h %h want 0000 0 0 0", out_valid, out00, out01, out11);
    end
  endtask

  initial begin
    rst = 1'b1; selector = 2'd0; in_valid = 1'b0; in_data = '0; out_ready = 4'b0000;
    test_reset();
    test_single_route();
    test_back_pressure();
    test_streaming();
    test_round_robin();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
